// File: rtl/jtag_gpio_banks.sv
// jtag_gpio_banks: IEEE 1149.1 TAP controller that reaches banked GPIO
// output/enable shadow registers one bank at a time. SCAN_N picks the bank,
// and EXTEST/SAMPLE scan that bank's {enable, data} chain.
module jtag_gpio_banks #(
  parameter int          NR_BANKS       = 4,
  parameter int          GPIOS_PER_BANK = 8,
  parameter logic [31:0] IDCODE         = 32'h1000_0001,
  localparam int         N              = NR_BANKS * GPIOS_PER_BANK,
  localparam int         SW             = (NR_BANKS > 1) ? $clog2(NR_BANKS) : 1
) (
  input  logic         tck,
  input  logic         reset_,
  input  logic         tms,
  input  logic         tdi,
  output logic         tdo,
  output logic         tdo_oe,
  input  logic [N-1:0] gpio_inputs,
  output logic [N-1:0] gpio_outputs,
  output logic [N-1:0] gpio_outputs_ena
);

  localparam int G  = GPIOS_PER_BANK;
  localparam int CW = 2 * G;

  localparam logic [3:0] OP_EXTEST  = 4'h0;
  localparam logic [3:0] OP_SAMPLE  = 4'h1;
  localparam logic [3:0] OP_SCAN_N  = 4'h2;
  localparam logic [3:0] OP_IDCODE  = 4'hE;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  typedef enum logic [3:0] {
    S_TEST_LOGIC_RESET, S_RUN_TEST_IDLE,
    S_SELECT_DR, S_CAPTURE_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR, S_UPDATE_DR,
    S_SELECT_IR, S_CAPTURE_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPDATE_IR
  } tap_state_t;

  tap_state_t state_reg, state_next;

  // TAP phase strobes decoded from the current state
  logic capture_ir, shift_ir, update_ir;
  logic capture_dr, shift_dr, update_dr;
  logic enter_tlr;

  // instruction and data registers
  logic [3:0]    ir_reg, ir_shift_reg;
  logic          bypass_reg;
  logic [31:0]   idcode_shift_reg;
  logic [SW-1:0] scan_shift_reg, bank_sel_reg;
  logic [CW-1:0] chain_reg;

  // instruction decode and selected-bank views
  logic          sel_extest, sel_sample, sel_scan_n, sel_idcode, sel_bypass;
  logic [G-1:0]  sel_inputs, sel_ena;
  logic          tdo_next;

  // TAP state register
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) state_reg <= S_TEST_LOGIC_RESET;
    else         state_reg <= state_next;
  end

  // standard 1149.1 TMS transition table
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_TEST_LOGIC_RESET: state_next = tms ? S_TEST_LOGIC_RESET : S_RUN_TEST_IDLE;
      S_RUN_TEST_IDLE:    state_next = tms ? S_SELECT_DR : S_RUN_TEST_IDLE;
      S_SELECT_DR:        state_next = tms ? S_SELECT_IR : S_CAPTURE_DR;
      S_CAPTURE_DR:       state_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR:         state_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR:         state_next = tms ? S_UPDATE_DR : S_PAUSE_DR;
      S_PAUSE_DR:         state_next = tms ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR:         state_next = tms ? S_UPDATE_DR : S_SHIFT_DR;
      S_UPDATE_DR:        state_next = tms ? S_SELECT_DR : S_RUN_TEST_IDLE;
      S_SELECT_IR:        state_next = tms ? S_TEST_LOGIC_RESET : S_CAPTURE_IR;
      S_CAPTURE_IR:       state_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR:         state_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR:         state_next = tms ? S_UPDATE_IR : S_PAUSE_IR;
      S_PAUSE_IR:         state_next = tms ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR:         state_next = tms ? S_UPDATE_IR : S_SHIFT_IR;
      S_UPDATE_IR:        state_next = tms ? S_SELECT_DR : S_RUN_TEST_IDLE;
      default:            state_next = S_TEST_LOGIC_RESET;
    endcase
  end

  // per-state strobes; enter_tlr fires on every edge that lands in Test-Logic-Reset
  always_comb begin
    capture_ir = (state_reg == S_CAPTURE_IR);
    shift_ir   = (state_reg == S_SHIFT_IR);
    update_ir  = (state_reg == S_UPDATE_IR);
    capture_dr = (state_reg == S_CAPTURE_DR);
    shift_dr   = (state_reg == S_SHIFT_DR);
    update_dr  = (state_reg == S_UPDATE_DR);
    tdo_oe     = shift_ir || shift_dr;
    enter_tlr  = (state_next == S_TEST_LOGIC_RESET);
  end

  // instruction decode; unassigned opcodes fall back to BYPASS
  always_comb begin
    sel_extest = 1'b0;
    sel_sample = 1'b0;
    sel_scan_n = 1'b0;
    sel_idcode = 1'b0;
    sel_bypass = 1'b0;
    case (ir_reg)
      OP_EXTEST: sel_extest = 1'b1;
      OP_SAMPLE: sel_sample = 1'b1;
      OP_SCAN_N: sel_scan_n = 1'b1;
      OP_IDCODE: sel_idcode = 1'b1;
      default:   sel_bypass = 1'b1;
    endcase
  end

  // instruction register: capture/shift path plus the live instruction
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      ir_shift_reg <= '0;
      ir_reg       <= OP_IDCODE;
    end else begin
      if (capture_ir)    ir_shift_reg <= IR_CAPTURE;
      else if (shift_ir) ir_shift_reg <= {tdi, ir_shift_reg[3:1]};
      if (enter_tlr)      ir_reg <= OP_IDCODE;
      else if (update_ir) ir_reg <= ir_shift_reg;
    end
  end

  // route the selected bank's pad inputs and enable shadow to the capture path
  always_comb begin
    sel_inputs = '0;
    sel_ena    = '0;
    for (int b = 0; b < NR_BANKS; b++) begin
      if (bank_sel_reg == SW'(b)) begin
        sel_inputs = gpio_inputs[b*G +: G];
        sel_ena    = gpio_outputs_ena[b*G +: G];
      end
    end
  end

  // data registers: only the one chosen by the instruction captures or shifts
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      bypass_reg       <= 1'b0;
      idcode_shift_reg <= '0;
      scan_shift_reg   <= '0;
      chain_reg        <= '0;
    end else if (capture_dr) begin
      bypass_reg <= 1'b0;
      if (sel_idcode) idcode_shift_reg <= IDCODE;
      if (sel_scan_n) scan_shift_reg <= bank_sel_reg;
      if (sel_extest || sel_sample) chain_reg <= {sel_ena, sel_inputs};
    end else if (shift_dr) begin
      if (sel_bypass) bypass_reg <= tdi;
      if (sel_idcode) idcode_shift_reg <= {tdi, idcode_shift_reg[31:1]};
      // shift form works even when the register is a single bit wide
      if (sel_scan_n) scan_shift_reg <= (scan_shift_reg >> 1) | (SW'(tdi) << (SW - 1));
      if (sel_extest || sel_sample) chain_reg <= {tdi, chain_reg[CW-1:1]};
    end
  end

  // bank select: out-of-range SCAN_N writes are dropped
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_)
      bank_sel_reg <= '0;
    else if (enter_tlr)
      bank_sel_reg <= '0;
    else if (update_dr && sel_scan_n && (int'(scan_shift_reg) < NR_BANKS))
      bank_sel_reg <= scan_shift_reg;
  end

  // per-bank shadows; pins are driven straight from these flops
  for (genvar gi = 0; gi < NR_BANKS; gi++) begin : g_bank
    logic [G-1:0] out_shadow_reg;
    logic [G-1:0] ena_shadow_reg;
    logic         bank_write;

    assign bank_write = update_dr && sel_extest && (bank_sel_reg == SW'(gi));

    // EXTEST update loads this bank; Test-Logic-Reset drops enables but keeps data
    always_ff @(posedge tck or negedge reset_) begin
      if (!reset_) begin
        out_shadow_reg <= '0;
        ena_shadow_reg <= '0;
      end else if (enter_tlr) begin
        ena_shadow_reg <= '0;
      end else if (bank_write) begin
        out_shadow_reg <= chain_reg[G-1:0];
        ena_shadow_reg <= chain_reg[CW-1:G];
      end
    end

    assign gpio_outputs[gi*G +: G]     = out_shadow_reg;
    assign gpio_outputs_ena[gi*G +: G] = ena_shadow_reg;
  end

  // LSB of whichever register is currently shifting
  always_comb begin
    tdo_next = bypass_reg;
    if (shift_ir)                      tdo_next = ir_shift_reg[0];
    else if (sel_extest || sel_sample) tdo_next = chain_reg[0];
    else if (sel_scan_n)               tdo_next = scan_shift_reg[0];
    else if (sel_idcode)               tdo_next = idcode_shift_reg[0];
  end

  // tdo launches on the falling edge and holds outside the shift states
  always_ff @(negedge tck or negedge reset_) begin
    if (!reset_)                  tdo <= 1'b0;
    else if (shift_ir || shift_dr) tdo <= tdo_next;
  end

endmodule

// File: tb/tb_jtag_gpio_banks.sv
// tb_jtag_gpio_banks: randomized JTAG transactions against a bank-level model
// of the GPIO shadows. A second, smaller instance (3 banks, 2-bit SCAN_N)
// exercises rejection of out-of-range bank selects.
`timescale 1ns/1ps
module tb_jtag_gpio_banks;
  localparam int          NB   = 4;
  localparam int          G    = 8;
  localparam int          N    = NB * G;
  localparam logic [31:0] IDC  = 32'h1000_0001;
  localparam int          NB_B = 3;
  localparam int          G_B  = 4;
  localparam int          N_B  = NB_B * G_B;

  logic tck = 1'b0, reset_ = 1'b0, tms = 1'b1, tdi = 1'b0, sel_b = 1'b0;
  logic tms_a, tms_b, tdo_a, oe_a, tdo_b, oe_b;
  logic [N-1:0]   gin = '0, gout, gena;
  logic [N_B-1:0] gin_b = '0, gout_b, gena_b;
  int checks = 0, failures = 0;

  // reference model of the main instance
  logic [G-1:0] out_m [NB];
  logic [G-1:0] ena_m [NB];
  int           bank_sel_m;

  // the idle instance sees tms=0 so it parks in Run-Test/Idle
  assign tms_a = sel_b ? 1'b0 : tms;
  assign tms_b = sel_b ? tms : 1'b0;

  always #5 tck = ~tck;

  jtag_gpio_banks #(.NR_BANKS(NB), .GPIOS_PER_BANK(G), .IDCODE(IDC)) dut (
    .tck(tck), .reset_(reset_), .tms(tms_a), .tdi(tdi), .tdo(tdo_a), .tdo_oe(oe_a),
    .gpio_inputs(gin), .gpio_outputs(gout), .gpio_outputs_ena(gena));

  jtag_gpio_banks #(.NR_BANKS(NB_B), .GPIOS_PER_BANK(G_B), .IDCODE(IDC)) dut_b (
    .tck(tck), .reset_(reset_), .tms(tms_b), .tdi(tdi), .tdo(tdo_b), .tdo_oe(oe_b),
    .gpio_inputs(gin_b), .gpio_outputs(gout_b), .gpio_outputs_ena(gena_b));

  function automatic logic [N-1:0] exp_out();
    logic [N-1:0] v;
    for (int b = 0; b < NB; b++) v[b*G +: G] = out_m[b];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ena();
    logic [N-1:0] v;
    for (int b = 0; b < NB; b++) v[b*G +: G] = ena_m[b];
    return v;
  endfunction

  task automatic model_power_on();
    for (int b = 0; b < NB; b++) begin
      out_m[b] = '0;
      ena_m[b] = '0;
    end
    bank_sel_m = 0;
  endtask

  task automatic model_tlr();
    for (int b = 0; b < NB; b++) ena_m[b] = '0;
    bank_sel_m = 0;
  endtask

  // one tck period: sample tdo/oe after the falling edge, then present tms/tdi
  task automatic cyc(input logic m, input logic d, output logic o, output logic oe);
    @(negedge tck);
    #1;
    o  = sel_b ? tdo_b : tdo_a;
    oe = sel_b ? oe_b : oe_a;
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic step(input logic m, input logic d);
    logic o, oe;
    cyc(m, d, o, oe);
  endtask

  // Run-Test/Idle -> IR scan -> Run-Test/Idle
  task automatic scan_ir(input logic [3:0] v, output logic [3:0] cap, output logic oe_ok);
    logic o, oe;
    oe_ok = 1'b1;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, v[i], o, oe);
      cap[i] = o;
      oe_ok &= oe;
    end
    step(1, 0); step(0, 0);
    $display("scan_ir  in=%h out=%h", v, cap);
  endtask

  // Run-Test/Idle -> DR scan of len bits -> Run-Test/Idle
  task automatic scan_dr(input logic [63:0] v, input int len, output logic [63:0] cap,
                         output logic oe_ok);
    logic o, oe;
    cap = '0;
    oe_ok = 1'b1;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < len; i++) begin
      cyc(i == len - 1, v[i], o, oe);
      cap[i] = o;
      oe_ok &= oe;
    end
    step(1, 0); step(0, 0);
    $display("scan_dr  len=%0d in=%h out=%h", len, v, cap);
  endtask

  task automatic test_reset();
    logic [63:0] cap;
    logic ok;
    reset_ = 1'b0;
    gin = $urandom;
    #2;
    checks++; if (gout !== '0) begin failures++; $display("FAIL reset_outputs actual=%h required=0", gout); end
    checks++; if (gena !== '0) begin failures++; $display("FAIL reset_ena actual=%h required=0", gena); end
    checks++; if (tdo_a !== 1'b0 || oe_a !== 1'b0) begin
      failures++; $display("FAIL reset_tdo actual=%b/%b required=0/0", tdo_a, oe_a);
    end
    repeat (2) @(posedge tck);
    @(negedge tck);
    #1 reset_ = 1'b1;
    model_power_on();
    step(0, 0);
    scan_dr({$urandom, $urandom}, 32, cap, ok);
    checks++; if (cap[31:0] !== IDC) begin failures++; $display("FAIL idcode_after_reset actual=%h required=%h", cap[31:0], IDC); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tdo_oe_in_shift actual=%b required=1", ok); end
  endtask

  task automatic test_bypass();
    logic [3:0]  ircap;
    logic [63:0] cap;
    logic [15:0] d;
    logic ok;
    scan_ir(4'hF, ircap, ok);
    checks++; if (ircap !== 4'b0101) begin failures++; $display("FAIL capture_ir actual=%b required=0101", ircap); end
    scan_dr(64'hA5, 9, cap, ok);
    checks++; if (cap[8:0] !== {8'hA5, 1'b0}) begin failures++; $display("FAIL bypass_a5 actual=%h required=%h", cap[8:0], {8'hA5, 1'b0}); end
    scan_ir(4'h7, ircap, ok);
    d = 16'($urandom);
    scan_dr({48'h0, d}, 16, cap, ok);
    checks++; if (cap[15:0] !== {d[14:0], 1'b0}) begin failures++; $display("FAIL bypass_unknown_op actual=%h required=%h", cap[15:0], {d[14:0], 1'b0}); end
  endtask

  task automatic write_bank_sel(input int b);
    logic [3:0]  ircap;
    logic [63:0] cap;
    logic ok;
    scan_ir(4'h2, ircap, ok);
    scan_dr(64'(b), 2, cap, ok);
    checks++; if (cap[1:0] !== 2'(bank_sel_m)) begin failures++; $display("FAIL scan_n_capture actual=%0d required=%0d", cap[1:0], bank_sel_m); end
    bank_sel_m = b;
  endtask

  task automatic extest_write(input logic [15:0] chain);
    logic [3:0]  ircap;
    logic [63:0] cap;
    logic ok;
    scan_ir(4'h0, ircap, ok);
    scan_dr({48'h0, chain}, 16, cap, ok);
    checks++; if (cap[15:0] !== {ena_m[bank_sel_m], gin[bank_sel_m*G +: G]}) begin
      failures++; $display("FAIL extest_capture actual=%h required=%h", cap[15:0], {ena_m[bank_sel_m], gin[bank_sel_m*G +: G]});
    end
    out_m[bank_sel_m] = chain[7:0];
    ena_m[bank_sel_m] = chain[15:8];
    checks++; if (gout !== exp_out() || gena !== exp_ena()) begin
      failures++; $display("FAIL extest_update actual=%h/%h required=%h/%h", gout, gena, exp_out(), exp_ena());
    end
  endtask

  task automatic test_scan_n();
    write_bank_sel(2);
    write_bank_sel(2);
  endtask

  task automatic test_extest();
    for (int k = 0; k < 6; k++) begin
      write_bank_sel($urandom_range(0, NB - 1));
      gin = $urandom;
      extest_write(16'($urandom));
    end
    write_bank_sel(2);
    extest_write(16'hFF3C);
    checks++; if (gout[23:16] !== 8'h3C || gena[23:16] !== 8'hFF) begin
      failures++; $display("FAIL extest_bank2 actual=%h/%h required=3c/ff", gout[23:16], gena[23:16]);
    end
  endtask

  task automatic test_sample();
    logic [3:0]  ircap;
    logic [63:0] cap;
    logic ok;
    gin = $urandom;
    gin[23:16] = 8'h81;
    scan_ir(4'h1, ircap, ok);
    scan_dr({$urandom, $urandom}, 16, cap, ok);
    checks++; if (cap[15:0] !== {ena_m[2], 8'h81}) begin failures++; $display("FAIL sample_capture actual=%h required=%h", cap[15:0], {ena_m[2], 8'h81}); end
    checks++; if (gout !== exp_out() || gena !== exp_ena()) begin
      failures++; $display("FAIL sample_no_update actual=%h/%h required=%h/%h", gout, gena, exp_out(), exp_ena());
    end
  endtask

  task automatic test_scan_n_invalid();
    logic [3:0]  ircap;
    logic [63:0] cap;
    logic ok;
    int bs_m, v;
    int seq [6] = '{1, 3, 0, 2, 3, 1};
    sel_b = 1'b1;
    bs_m = 0;
    scan_ir(4'h2, ircap, ok);
    checks++; if (ircap !== 4'b0101) begin failures++; $display("FAIL b_capture_ir actual=%b required=0101", ircap); end
    for (int k = 0; k < 12; k++) begin
      v = (k < 6) ? seq[k] : int'($urandom_range(0, 3));
      scan_dr(64'(v), 2, cap, ok);
      checks++; if (cap[1:0] !== 2'(bs_m)) begin failures++; $display("FAIL b_bank_sel actual=%0d required=%0d", cap[1:0], bs_m); end
      if (v < NB_B) bs_m = v;
    end
    checks++; if (gena_b !== '0) begin failures++; $display("FAIL b_ena actual=%h required=0", gena_b); end
    sel_b = 1'b0;
  endtask

  task automatic test_tlr_random();
    logic [3:0]  ircap;
    logic [63:0] cap;
    logic ok;
    for (int it = 0; it < 3; it++) begin
      write_bank_sel($urandom_range(1, NB - 1));
      extest_write(16'($urandom) | 16'h0100);
      scan_ir(4'hF, ircap, ok);
      // tdi held high keeps any IR the walk loads away from EXTEST/SCAN_N/SAMPLE
      repeat ($urandom_range(3, 25)) step(1'($urandom), 1'b1);
      repeat (5) step(1'b1, 1'b1);
      model_tlr();
      checks++; if (gena !== '0) begin failures++; $display("FAIL tlr_ena actual=%h required=0", gena); end
      checks++; if (gout !== exp_out()) begin failures++; $display("FAIL tlr_outputs_kept actual=%h required=%h", gout, exp_out()); end
      checks++; if (oe_a !== 1'b0) begin failures++; $display("FAIL tlr_oe actual=%b required=0", oe_a); end
      step(0, 0);
      scan_dr({$urandom, $urandom}, 32, cap, ok);
      checks++; if (cap[31:0] !== IDC) begin failures++; $display("FAIL tlr_idcode actual=%h required=%h", cap[31:0], IDC); end
      write_bank_sel(0);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [3:0]  ircap;
    logic [63:0] cap;
    logic ok;
    write_bank_sel(1);
    extest_write(16'($urandom) | 16'h0101);
    scan_ir(4'h0, ircap, ok);
    step(1, 0); step(0, 0); step(0, 0);
    repeat (5) step(0, 1'($urandom));
    @(negedge tck);
    #2 reset_ = 1'b0;
    #1;
    model_power_on();
    checks++; if (gout !== '0 || gena !== '0) begin failures++; $display("FAIL midshift_outputs actual=%h/%h required=0/0", gout, gena); end
    checks++; if (tdo_a !== 1'b0 || oe_a !== 1'b0) begin failures++; $display("FAIL midshift_tdo actual=%b/%b required=0/0", tdo_a, oe_a); end
    @(negedge tck);
    #1 reset_ = 1'b1;
    tms = 1'b0;
    step(0, 0);
    scan_dr({$urandom, $urandom}, 32, cap, ok);
    checks++; if (cap[31:0] !== IDC) begin failures++; $display("FAIL midshift_tlr_idcode actual=%h required=%h", cap[31:0], IDC); end
    checks++; if (gout !== exp_out() || gena !== exp_ena()) begin
      failures++; $display("FAIL midshift_after actual=%h/%h required=%h/%h", gout, gena, exp_out(), exp_ena());
    end
  endtask

  initial begin
    gin_b = N_B'($urandom);
    test_reset();
    test_bypass();
    test_scan_n();
    test_extest();
    test_sample();
    test_scan_n_invalid();
    test_tlr_random();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
